// File: rtl/timer_pkg.sv
// Shared types and default sizing for the toggle-driven countdown timer.
package timer_pkg;

    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_CNT_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } timer_state_e;

endpackage

// File: rtl/toggle_sync_edge.sv
// Synchronizes the divider toggle into clk_in and produces a one-cycle raw edge pulse,
// held off while the chain fills after reset.
module toggle_sync_edge
    import timer_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter bit          BOTH_EDGES  = 1'b1
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic toggle_in,
    output logic edge_c
);

    localparam int unsigned WARM   = SYNC_STAGES + 1;
    localparam int unsigned WARM_W = $clog2(WARM + 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   hist;
    logic [WARM_W-1:0]      warm_cnt;
    logic                   armed;
    logic                   raw;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync     <= '0;
            hist     <= 1'b0;
            warm_cnt <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], toggle_in};
            hist <= sync[SYNC_STAGES-1];
            if (!armed) begin
                warm_cnt <= warm_cnt + WARM_W'(1);
            end
        end
    end

    // A level present at reset release ripples through the chain; ignore it until settled.
    assign armed  = (warm_cnt == WARM_W'(WARM));
    assign raw    = BOTH_EDGES ? (sync[SYNC_STAGES-1] ^ hist)
                               : (sync[SYNC_STAGES-1] & ~hist);
    assign edge_c = armed & raw;

endmodule

// File: rtl/toggle_tick_timer.sv
// Turns divider toggles into clk_in tick strobes and runs a loadable countdown
// timer (IDLE/RUN/EXPIRED) with start/stop control and a done pulse.
module toggle_tick_timer
    import timer_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter bit          BOTH_EDGES  = 1'b1
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             toggle_in,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             start,
    input  logic             stop,
    output logic             tick,
    output logic [CNT_W-1:0] count,
    output logic             running,
    output logic             done,
    output logic             expired
);

    timer_state_e state;
    logic         edge_c;

    toggle_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .BOTH_EDGES  (BOTH_EDGES)
    ) u_sync_edge (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .toggle_in (toggle_in),
        .edge_c    (edge_c)
    );

    // Priority: load > stop > start > tick-decrement.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            tick    <= 1'b0;
            count   <= '0;
            running <= 1'b0;
            done    <= 1'b0;
            expired <= 1'b0;
        end else begin
            tick <= edge_c;
            done <= 1'b0;
            if (load) begin
                count   <= load_value;
                state   <= ST_IDLE;
                running <= 1'b0;
                expired <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start && (count != '0)) begin
                            state   <= ST_RUN;
                            running <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (stop) begin
                            state   <= ST_IDLE;
                            running <= 1'b0;
                        end else if (edge_c) begin
                            if (count == CNT_W'(1)) begin
                                count   <= '0;
                                done    <= 1'b1;
                                state   <= ST_EXPIRED;
                                running <= 1'b0;
                                expired <= 1'b1;
                            end else if (count != '0) begin
                                count <= count - CNT_W'(1);
                            end
                        end
                    end
                    ST_EXPIRED: begin
                        count <= '0;
                    end
                    default: begin
                        state   <= ST_IDLE;
                        running <= 1'b0;
                        expired <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_toggle_tick_timer.sv
// Scoreboard bench: stimulus queues hand-computed per-cycle expectations, a negedge monitor checks them.
module tb_toggle_tick_timer;

    logic       clk_in = 1'b0;
    logic       rst_n;
    logic       toggle_in;
    logic       load;
    logic [7:0] load_value;
    logic       start;
    logic       stop;

    logic       tick, running, done, expired;
    logic [7:0] count;
    logic       tick_re, running_re, done_re, expired_re;
    logic [7:0] count_re;

    typedef struct {
        int         cyc;
        string      nm;
        logic [7:0] count;
        logic       running;
        logic       expired;
        logic       done;
        logic       tick;
        logic       tick_re;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   t;

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    toggle_tick_timer #(.SYNC_STAGES(2), .CNT_W(8), .BOTH_EDGES(1'b1)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .toggle_in(toggle_in), .load(load),
        .load_value(load_value), .start(start), .stop(stop), .tick(tick),
        .count(count), .running(running), .done(done), .expired(expired)
    );

    toggle_tick_timer #(.SYNC_STAGES(2), .CNT_W(8), .BOTH_EDGES(1'b0)) dut_re (
        .clk_in(clk_in), .rst_n(rst_n), .toggle_in(toggle_in), .load(load),
        .load_value(load_value), .start(start), .stop(stop), .tick(tick_re),
        .count(count_re), .running(running_re), .done(done_re), .expired(expired_re)
    );

    task automatic expect_at(input int tag, input string nm, input logic [7:0] c,
                             input logic r, input logic x, input logic d,
                             input logic tk, input logic tkr);
        exp_t n;
        n.cyc = tag; n.nm = nm; n.count = c; n.running = r; n.expired = x;
        n.done = d; n.tick = tk; n.tick_re = tkr;
        q.push_back(n);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // Monitor: compare every expectation whose cycle tag has arrived.
    always @(negedge clk_in) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            n_checks++;
            if (e.cyc == cyc && count === e.count && running === e.running &&
                expired === e.expired && done === e.done && tick === e.tick &&
                tick_re === e.tick_re) begin
                n_pass++;
            end else begin
                $display("FAIL %s tag=%0d now=%0d got count=%0d run=%0b exp=%0b done=%0b tick=%0b tick_re=%0b want count=%0d run=%0b exp=%0b done=%0b tick=%0b tick_re=%0b",
                         e.nm, e.cyc, cyc, count, running, expired, done, tick, tick_re,
                         e.count, e.running, e.expired, e.done, e.tick, e.tick_re);
            end
        end
    end

    initial begin
        rst_n = 1'b0; toggle_in = 1'b1; load = 1'b0; load_value = 8'd0;
        start = 1'b0; stop = 1'b0;

        // Reset with toggle_in held high, then warm-up window
        step(3);
        t = cyc;
        expect_at(t, "reset", 8'd0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        for (int i = 1; i <= 20; i++) expect_at(t + i, "warmup", 8'd0, 0, 0, 0, 0, 0);
        step(20);

        // Falling toggle: both-edge ticks at E2, rising-only does not
        t = cyc; toggle_in = 1'b0;
        expect_at(t + 2, "fall_pre", 8'd0, 0, 0, 0, 0, 0);
        expect_at(t + 3, "fall_tick", 8'd0, 0, 0, 0, 1, 0);
        expect_at(t + 4, "fall_post", 8'd0, 0, 0, 0, 0, 0);
        step(6);

        // Rising toggle: both instances tick
        t = cyc; toggle_in = 1'b1;
        expect_at(t + 2, "rise_pre", 8'd0, 0, 0, 0, 0, 0);
        expect_at(t + 3, "rise_tick", 8'd0, 0, 0, 0, 1, 1);
        expect_at(t + 4, "rise_post", 8'd0, 0, 0, 0, 0, 0);
        step(6);

        // Full countdown from 3
        t = cyc; load = 1'b1; load_value = 8'd3;
        expect_at(t + 1, "load3", 8'd3, 0, 0, 0, 0, 0);
        step(1);
        t = cyc; load = 1'b0; start = 1'b1;
        expect_at(t + 1, "start3", 8'd3, 1, 0, 0, 0, 0);
        step(1);
        t = cyc; start = 1'b0; toggle_in = 1'b0;
        expect_at(t + 2, "cd2_pre", 8'd3, 1, 0, 0, 0, 0);
        expect_at(t + 3, "cd2", 8'd2, 1, 0, 0, 1, 0);
        step(4);
        t = cyc; toggle_in = 1'b1;
        expect_at(t + 3, "cd1", 8'd1, 1, 0, 0, 1, 1);
        step(4);
        t = cyc; toggle_in = 1'b0;
        expect_at(t + 3, "cd0_done", 8'd0, 0, 1, 1, 1, 0);
        expect_at(t + 4, "done_once", 8'd0, 0, 1, 0, 0, 0);
        step(4);
        t = cyc; toggle_in = 1'b1; start = 1'b1; stop = 1'b1;
        expect_at(t + 1, "exp_ignore", 8'd0, 0, 1, 0, 0, 0);
        expect_at(t + 3, "exp_hold", 8'd0, 0, 1, 0, 1, 1);
        step(1);
        start = 1'b0; stop = 1'b0;
        step(4);

        // Pause with a coincident tick, then resume
        t = cyc; load = 1'b1; load_value = 8'd5;
        step(1);
        load = 1'b0; start = 1'b1;
        step(1);
        t = cyc; start = 1'b0;
        expect_at(t, "run5", 8'd5, 1, 0, 0, 0, 0);
        toggle_in = 1'b0;
        step(2);
        stop = 1'b1;
        expect_at(t + 3, "pause", 8'd5, 0, 0, 0, 1, 0);
        step(1);
        stop = 1'b0;
        step(2);
        t = cyc; start = 1'b1;
        expect_at(t + 1, "resume", 8'd5, 1, 0, 0, 0, 0);
        step(1);
        t = cyc; start = 1'b0; toggle_in = 1'b1;
        expect_at(t + 3, "resume_dec", 8'd4, 1, 0, 0, 1, 1);
        step(4);

        // Load beats a same-cycle final tick
        load = 1'b1; load_value = 8'd1;
        step(1);
        load = 1'b0; start = 1'b1;
        step(1);
        t = cyc; start = 1'b0; toggle_in = 1'b0;
        step(2);
        load = 1'b1; load_value = 8'd9;
        expect_at(t + 3, "load_pri", 8'd9, 0, 0, 0, 1, 0);
        expect_at(t + 4, "load_nodone", 8'd9, 0, 0, 0, 0, 0);
        step(1);
        load = 1'b0;
        step(2);

        // Start with count 0 is ignored
        t = cyc; load = 1'b1; load_value = 8'd0;
        step(1);
        t = cyc; load = 1'b0; start = 1'b1;
        expect_at(t + 1, "start0", 8'd0, 0, 0, 0, 0, 0);
        step(1);
        start = 1'b0;
        step(1);

        // Asynchronous reset in RUN at count 7
        load = 1'b1; load_value = 8'd7;
        step(1);
        load = 1'b0; start = 1'b1;
        step(1);
        t = cyc; start = 1'b0;
        expect_at(t, "run7", 8'd7, 1, 0, 0, 0, 0);
        @(posedge clk_in);
        #2;
        rst_n = 1'b0;
        expect_at(cyc, "async_rst", 8'd0, 0, 0, 0, 0, 0);
        step(1);
        rst_n = 1'b1;
        t = cyc;
        expect_at(t + 2, "after_rst", 8'd0, 0, 0, 0, 0, 0);
        step(3);

        for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge clk_in);
        if (q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations pending, want 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/toggle_tick_timer.md
# toggle_tick_timer

Consumes the slow toggling clock from the team's clock divider inside the fast clock domain and turns each toggle into a one-cycle tick strobe. It drives a loadable countdown timer with start/stop control and an expiry pulse. Sits between the divider and the display/conversion logic, so downstream blocks run on `clk_in` with enables instead of a derived clock.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth on `toggle_in`; legal values are 2 or more.
- `CNT_W`, default 8: width of the countdown counter.
- `BOTH_EDGES`, default 1:
  - 1: every toggle of `toggle_in` is a tick.
  - 0: only rising edges are ticks.
- `clk_in`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `toggle_in`  in  1  divider output; treated as asynchronous.
- `load`  in  1  one-cycle request to load `load_value`.
- `load_value`  in  CNT_W  countdown start value.
- `start`  in  1  one-cycle request to begin or resume counting.
- `stop`  in  1  one-cycle request to pause counting.
- `tick`  out  1  one-cycle strobe per qualifying `toggle_in` edge; free-running, independent of timer state.
- `count`  out  CNT_W  current countdown value.
- `running`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse when `count` reaches 0.
- `expired`  out  1  high in EXPIRED.

## Operation
- **Edge path:**
  - `toggle_in` passes through `SYNC_STAGES` flops, then a history flop.
  - A raw edge is the synchronized value XOR the history value. With `BOTH_EDGES`=0, it is synchronized AND NOT history.
  - Edge detection is suppressed until `SYNC_STAGES`+1 edges after reset release. A high `toggle_in` at reset therefore never produces a spurious tick.
- **FSM states:** IDLE, RUN, EXPIRED. The reset state is IDLE.
- **Priority within one cycle:** `load` > `stop` > `start` > tick-decrement.
- **`load` (any state):**
  - `count` <= `load_value`; next state is IDLE.
  - Any same-cycle tick does not decrement.
- **IDLE:**
  - `start` with `count`≠0 moves to RUN.
  - `start` with `count`=0 is ignored and the state stays IDLE.
  - Ticks do not change `count`.
- **RUN:**
  - `stop` moves to IDLE with `count` retained; a same-cycle tick is discarded.
  - A tick with `count`>1 sets `count`-1.
  - A tick with `count`=1 sets `count`=0, pulses `done`, and moves to EXPIRED.
  - `start` is ignored.
- **EXPIRED:**
  - `start` and `stop` are ignored.
  - `count` holds 0.
  - Only `load` exits.
- **Arithmetic:** unsigned. `count` never decrements below 0 and never wraps.
- **Reset values:** `tick`=0, `count`=0, `running`=0, `done`=0, `expired`=0. All synchronizer and history flops are 0.
- **Reset mid-count:** all state is lost immediately (asynchronous). After release, the block behaves as if freshly powered.

## Timing
- Let E0 be the first rising edge of `clk_in` that samples a new `toggle_in` level.
- `tick` is registered and is high for exactly one cycle following edge E_{SYNC_STAGES}. With the default, that is after E2.
- A RUN decrement occurs on the same edge that asserts `tick`.
- `done` is registered and asserts on the same edge at which `count` becomes 0.
- `running` and `expired` are registered state decodes. They change on the edge that changes state.
- Control inputs (`load`, `start`, `stop`) take effect on the next rising edge, with 0 cycles of latency to `count` and state.
- Minimum `toggle_in` level time is `SYNC_STAGES`+1 `clk_in` cycles. Shorter pulses may be lost; this is not an error.
- Back-to-back ticks spaced one cycle apart must each decrement once.

## Structure
- **Shared package `timer_pkg`:**
  - state enum typedef (IDLE/RUN/EXPIRED);
  - default `SYNC_STAGES` and `CNT_W` constants.
- **Sub-module `toggle_sync_edge`:**
  - holds the synchronizer chain, history flop, warm-up suppression and edge-mode select;
  - output is a single-cycle raw edge pulse.
- **Top level:** FSM, counter, registered outputs.

## Test plan
- **Warm-up:** hold `toggle_in`=1 through reset, then release → no `tick` in the first 20 cycles.
- **Tick latency:** toggle `toggle_in` 0→1 before E0 with `SYNC_STAGES`=2 → `tick` is high for one cycle after E2.
  - With `BOTH_EDGES`=1, 1→0 also ticks.
  - With `BOTH_EDGES`=0, 1→0 does not tick.
- **Full countdown:** `load_value`=3, `load`, `start`, then three toggles.
  - `count` goes 3→2→1→0.
  - `done` pulses once, coincident with 0.
  - `expired`=1 and `running`=0.
  - A further tick leaves `count`=0.
- **Pause/resume:** with `count`=5 in RUN, assert `stop` in the same cycle as a tick → `count` stays 5 and the state is IDLE. Then `start` plus a tick → 4.
- **Priority:**
  - In RUN with `count`=1, assert `load` (`load_value`=9) in the same cycle as a tick → `count`=9, IDLE, no `done`.
  - `start` with `count`=0 in IDLE → stays IDLE.
- **Async reset mid-run:** at `count`=7 in RUN, pulse `rst_n` low between clock edges → all outputs go to 0 immediately, without waiting for a clock.
